// File: rtl/aq_fifo_sync_ctrl.sv
// Single-clock FIFO controller around a registered-read RAM, with a 2-entry
// output stage (output + skid register) giving first-word-fall-through reads.

module aq_fifo_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             WR_CLK,
  input  logic             WR_EN,
  input  logic [DEPTH-1:0] WR_ADRS,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             RD_CLK,
  input  logic [DEPTH-1:0] RD_ADRS,
  output logic [WIDTH-1:0] RD_DATA
);

  logic [WIDTH-1:0] mem [2**DEPTH];

  always_ff @(posedge WR_CLK) begin
    if (WR_EN) mem[WR_ADRS] <= WR_DATA;
  end

  always_ff @(posedge RD_CLK) begin
    RD_DATA <= mem[RD_ADRS];
  end

endmodule

module aq_fifo_sync_ctrl #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int AFULL_LVL = 2**DEPTH - 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic [DEPTH:0]   COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ALMOST_FULL
);

  localparam logic [DEPTH:0] CAP_C   = (DEPTH+1)'(2**DEPTH);
  localparam logic [DEPTH:0] AFULL_C = (DEPTH+1)'(AFULL_LVL);

  logic [DEPTH:0]   wrPtr_q, wrPtr_d;
  logic [DEPTH:0]   rdPtr_q, rdPtr_d;
  logic [DEPTH:0]   count_q, count_d;
  logic             rdPending_q, rdPending_d;
  logic             outValid_q, outValid_d;
  logic             skidValid_q, skidValid_d;
  logic             readyEn_q;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic [WIDTH-1:0] ramRdData;

  logic       push;
  logic       pop;
  logic       ramNonEmpty;
  logic [1:0] stageOcc;
  logic       issue;

  aq_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) uRam (
    .WR_CLK  (CLK),
    .WR_EN   (push),
    .WR_ADRS (wrPtr_q[DEPTH-1:0]),
    .WR_DATA (S_DATA),
    .RD_CLK  (CLK),
    .RD_ADRS (rdPtr_q[DEPTH-1:0]),
    .RD_DATA (ramRdData)
  );

  // Ready comes from registered COUNT only; readyEn_q keeps it low until the first edge after reset.
  assign S_READY     = readyEn_q & (count_q < CAP_C);
  assign push        = S_VALID & S_READY;
  assign pop         = outValid_q & M_READY;
  assign ramNonEmpty = (wrPtr_q != rdPtr_q);
  assign stageOcc    = {1'b0, outValid_q} + {1'b0, skidValid_q} + {1'b0, rdPending_q};
  assign issue       = ramNonEmpty & (stageOcc < (2'd2 + {1'b0, pop}));

  assign M_VALID     = outValid_q;
  assign M_DATA      = outData_q;
  assign COUNT       = count_q;
  assign FULL        = (count_q == CAP_C);
  assign EMPTY       = (count_q == '0);
  assign ALMOST_FULL = (count_q >= AFULL_C);

  always_comb begin
    wrPtr_d     = push  ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d     = issue ? rdPtr_q + 1'b1 : rdPtr_q;
    rdPending_d = issue;
    count_d     = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // The skid register always holds the newer word; RAM data lands in whichever slot is free after the pop.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (pop) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outData_d   = skidData_q;
        skidValid_d = rdPending_q;
        if (rdPending_q) skidData_d = ramRdData;
      end else if (rdPending_q) begin
        outValid_d = 1'b1;
        outData_d  = ramRdData;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (rdPending_q) begin
      if (!outValid_q) begin
        outValid_d = 1'b1;
        outData_d  = ramRdData;
      end else begin
        skidValid_d = 1'b1;
        skidData_d  = ramRdData;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      rdPending_q <= 1'b0;
      outValid_q  <= 1'b0;
      skidValid_q <= 1'b0;
      readyEn_q   <= 1'b0;
      outData_q   <= '0;
      skidData_q  <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      rdPending_q <= rdPending_d;
      outValid_q  <= outValid_d;
      skidValid_q <= skidValid_d;
      readyEn_q   <= 1'b1;
      outData_q   <= outData_d;
      skidData_q  <= skidData_d;
    end
  end

endmodule

// File: tb/tb_aq_fifo_sync_ctrl.sv
// Self-checking bench: a queue model predicts every output each cycle; a word
// becomes visible two edges after its push once it reaches the queue head.

module tb_aq_fifo_sync_ctrl;

  localparam int DEPTH = 3;
  localparam int WIDTH = 32;
  localparam int AFULL = 4;
  localparam int CAP   = 2**DEPTH;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             S_VALID = 1'b0;
  logic             S_READY;
  logic [WIDTH-1:0] S_DATA = '0;
  logic             M_VALID;
  logic             M_READY = 1'b0;
  logic [WIDTH-1:0] M_DATA;
  logic [DEPTH:0]   COUNT;
  logic             FULL;
  logic             EMPTY;
  logic             ALMOST_FULL;

  int checks = 0;
  int errors = 0;

  aq_fifo_sync_ctrl #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .AFULL_LVL (AFULL)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .S_VALID     (S_VALID),
    .S_READY     (S_READY),
    .S_DATA      (S_DATA),
    .M_VALID     (M_VALID),
    .M_READY     (M_READY),
    .M_DATA      (M_DATA),
    .COUNT       (COUNT),
    .FULL        (FULL),
    .EMPTY       (EMPTY),
    .ALMOST_FULL (ALMOST_FULL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               stamp;
  } entry_t;

  entry_t q[$];
  int     edgeNum = 0;
  logic   rdyEn = 1'b0;

  function automatic logic expValid();
    return (q.size() > 0) && ((edgeNum - q[0].stamp) >= 2);
  endfunction

  function automatic logic expReady();
    return rdyEn && (q.size() < CAP);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is held from its push edge until its pop edge.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete();
      rdyEn <= 1'b0;
    end else begin
      logic doPush, doPop;
      entry_t e;
      doPush = S_VALID && expReady();
      doPop  = M_READY && expValid();
      if (doPop) void'(q.pop_front());
      if (doPush) begin
        e.data  = S_DATA;
        e.stamp = edgeNum + 1;
        q.push_back(e);
      end
      edgeNum <= edgeNum + 1;
      rdyEn   <= 1'b1;
    end
  end

  always @(negedge CLK) begin
    checkOutput("s_ready", 32'(S_READY), 32'(expReady()));
    checkOutput("m_valid", 32'(M_VALID), 32'(expValid()));
    if (expValid()) checkOutput("m_data", M_DATA, q[0].data);
    checkOutput("count", 32'(COUNT), 32'(q.size()));
    checkOutput("full", 32'(FULL), 32'(q.size() == CAP));
    checkOutput("empty", 32'(EMPTY), 32'(q.size() == 0));
    checkOutput("almost_full", 32'(ALMOST_FULL), 32'(q.size() >= AFULL));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic sv, input logic [WIDTH-1:0] sd, input logic mr);
    S_VALID = sv;
    S_DATA  = sd;
    M_READY = mr;
    tick();
  endtask

  initial begin
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    S_VALID = 1'b1;
    S_DATA  = 32'hDEAD_BEEF;

    // Held in reset with a write request pending
    tick(); tick(); tick();
    checkOutput("rst_s_ready", 32'(S_READY), 32'd0);
    checkOutput("rst_m_valid", 32'(M_VALID), 32'd0);
    checkOutput("rst_m_data", M_DATA, 32'd0);
    checkOutput("rst_empty", 32'(EMPTY), 32'd1);
    checkOutput("rst_full", 32'(FULL), 32'd0);
    checkOutput("rst_count", 32'(COUNT), 32'd0);
    RST_N = 1'b1;
    #1;
    checkOutput("rel_s_ready_before_edge", 32'(S_READY), 32'd0);
    tick();
    checkOutput("rel_s_ready_after_edge", 32'(S_READY), 32'd1);
    checkOutput("rel_count", 32'(COUNT), 32'd0);

    // Two-edge latency from push to output
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b1);
    checkOutput("lat_k_valid", 32'(M_VALID), 32'd0);
    checkOutput("lat_k_count", 32'(COUNT), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_k1_valid", 32'(M_VALID), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_k2_valid", 32'(M_VALID), 32'd1);
    checkOutput("lat_k2_data", M_DATA, 32'hA5A5_0001);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_pop_count", 32'(COUNT), 32'd0);
    checkOutput("lat_pop_valid", 32'(M_VALID), 32'd0);

    // Fill to capacity with the consumer stalled
    for (int i = 0; i < CAP; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0);
      if (i == 2) checkOutput("fill_afull_3", 32'(ALMOST_FULL), 32'd0);
      if (i == 3) checkOutput("fill_afull_4", 32'(ALMOST_FULL), 32'd1);
    end
    checkOutput("fill_count", 32'(COUNT), 32'd8);
    checkOutput("fill_full", 32'(FULL), 32'd1);
    checkOutput("fill_s_ready", 32'(S_READY), 32'd0);
    applyStimulus(1'b1, 32'h99, 1'b0);
    checkOutput("fill_ninth_count", 32'(COUNT), 32'd8);
    checkOutput("fill_head", M_DATA, 32'd0);
    applyStimulus(1'b1, 32'h99, 1'b1);
    checkOutput("fill_pop_count", 32'(COUNT), 32'd7);
    checkOutput("fill_pop_s_ready", 32'(S_READY), 32'd1);
    checkOutput("fill_pop_head", M_DATA, 32'd1);
    applyStimulus(1'b1, 32'h99, 1'b0);
    checkOutput("fill_refill_count", 32'(COUNT), 32'd8);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (j < 6)       checkOutput("drain_data", M_DATA, 32'(j + 2));
      else if (j == 6) checkOutput("drain_last", M_DATA, 32'h99);
      else             checkOutput("drain_empty", 32'(EMPTY), 32'd1);
    end

    // Back-to-back streaming across three pointer wraps
    for (int i = 0; i < 3*CAP; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1);
      if (i >= 2) begin
        checkOutput("stream_valid", 32'(M_VALID), 32'd1);
        checkOutput("stream_data", M_DATA, 32'h100 + 32'(i - 2));
      end
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("stream_tail0", M_DATA, 32'h100 + 32'(3*CAP - 2));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("stream_tail1", M_DATA, 32'h100 + 32'(3*CAP - 1));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("stream_done", 32'(M_VALID), 32'd0);

    // Random backpressure with mostly continuous pushes
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 9) != 0, $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("bp_drained", 32'(EMPTY), 32'd1);

    // Asynchronous reset while holding five words and a read in flight
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h50 + 32'(i), 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b1);
    checkOutput("mid_count", 32'(COUNT), 32'd5);
    S_VALID = 1'b0;
    M_READY = 1'b0;
    #1 RST_N = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(M_VALID), 32'd0);
    checkOutput("mid_rst_count", 32'(COUNT), 32'd0);
    checkOutput("mid_rst_empty", 32'(EMPTY), 32'd1);
    checkOutput("mid_rst_s_ready", 32'(S_READY), 32'd0);
    #1 RST_N = 1'b1;
    tick();
    checkOutput("mid_rel_s_ready", 32'(S_READY), 32'd1);
    applyStimulus(1'b1, 32'h1234, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("mid_k1_valid", 32'(M_VALID), 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("mid_k2_valid", 32'(M_VALID), 32'd1);
    checkOutput("mid_k2_data", M_DATA, 32'h1234);
    checkOutput("mid_k2_count", 32'(COUNT), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_pop_count", 32'(COUNT), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_alone", 32'(M_VALID), 32'd0);

    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
